// File: rtl/led_blink_bank.sv
// led_blink_bank: multi-channel programmable LED flasher sharing one time-base prescaler (define LED_SYNC_EN to add the sync realign input)
module led_blink_bank #(
    parameter int N_CH     = 8,
    parameter int TICK_DIV = 50000,
    parameter int PER_W    = 12
) (
    input  logic                                    clk,
    input  logic                                    aclr,
`ifdef LED_SYNC_EN
    input  logic                                    sync,
`endif
    input  logic                                    cfg_we,
    input  logic [$clog2(N_CH > 1 ? N_CH : 2)-1:0]  cfg_ch,
    input  logic [1:0]                              cfg_mode,
    input  logic [PER_W-1:0]                        cfg_per,
    input  logic [PER_W-1:0]                        cfg_high,
    output logic [N_CH-1:0]                         led,
    output logic [N_CH-1:0]                         busy,
    output logic                                    tick
);
    localparam int CH_W = $bits(cfg_ch);
    localparam int PC_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_ONESHOT} mode_e;

    logic [PC_W-1:0]  pc_q, pc_d;
    mode_e            mode_q [N_CH];
    mode_e            mode_d [N_CH];
    logic [PER_W-1:0] per_q  [N_CH];
    logic [PER_W-1:0] per_d  [N_CH];
    logic [PER_W-1:0] high_q [N_CH];
    logic [PER_W-1:0] high_d [N_CH];
    logic [PER_W-1:0] ph_q   [N_CH];
    logic [PER_W-1:0] ph_d   [N_CH];
    logic [PER_W-1:0] pe     [N_CH];
    logic [N_CH-1:0]  act_q, act_d;
    logic [N_CH-1:0]  led_q, led_d;
    logic [N_CH-1:0]  busy_q, busy_d;
    logic             wr_ok;

    assign led  = led_q;
    assign busy = busy_q;

    // Prescaler and per-channel next state; a write beats sync, and sync beats tick
    always_comb begin
        tick  = pc_q == PC_W'(TICK_DIV - 1);
        pc_d  = tick ? '0 : pc_q + 1'b1;
        wr_ok = cfg_we && ({1'b0, cfg_ch} < (CH_W + 1)'(N_CH));
`ifdef LED_SYNC_EN
        if (sync) pc_d = '0;
`endif
        for (int i = 0; i < N_CH; i++) begin
            mode_d[i] = mode_q[i];
            per_d[i]  = per_q[i];
            high_d[i] = high_q[i];
            ph_d[i]   = ph_q[i];
            act_d[i]  = act_q[i];
            pe[i]     = (per_q[i] == '0) ? PER_W'(1) : per_q[i];
            if (tick && (mode_q[i] == M_BLINK || (mode_q[i] == M_ONESHOT && act_q[i]))) begin
                ph_d[i] = (ph_q[i] == pe[i] - 1'b1) ? '0 : ph_q[i] + 1'b1;
                if (mode_q[i] == M_ONESHOT && ph_q[i] == pe[i] - 1'b1) act_d[i] = 1'b0;
            end
`ifdef LED_SYNC_EN
            if (sync) ph_d[i] = '0;
`endif
            if (wr_ok && {1'b0, cfg_ch} == (CH_W + 1)'(i)) begin
                mode_d[i] = mode_e'(cfg_mode);
                per_d[i]  = cfg_per;
                high_d[i] = cfg_high;
                ph_d[i]   = '0;
                act_d[i]  = cfg_mode == 2'd3;
            end
            led_d[i]  = mode_q[i] == M_ON ||
                        ((mode_q[i] == M_BLINK || (mode_q[i] == M_ONESHOT && act_q[i])) && ph_q[i] < high_q[i]);
            busy_d[i] = act_q[i];
        end
    end

    // State and registered outputs; reset clears every channel and aborts pulses at once
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            pc_q   <= '0;
            mode_q <= '{default: M_OFF};
            per_q  <= '{default: '0};
            high_q <= '{default: '0};
            ph_q   <= '{default: '0};
            act_q  <= '0;
            led_q  <= '0;
            busy_q <= '0;
        end else begin
            pc_q   <= pc_d;
            mode_q <= mode_d;
            per_q  <= per_d;
            high_q <= high_d;
            ph_q   <= ph_d;
            act_q  <= act_d;
            led_q  <= led_d;
            busy_q <= busy_d;
        end
    end
endmodule

// File: tb/tb_led_blink_bank.sv
// tb_led_blink_bank: directed checks of the LED flasher at TICK_DIV=4 with six channels
module tb_led_blink_bank;
    localparam int N_CH = 6;
    localparam int TD   = 4;
    localparam int PW   = 4;

    logic          clk = 1'b0;
    logic          aclr = 1'b1;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_ch = '0;
    logic [1:0]    cfg_mode = '0;
    logic [PW-1:0] cfg_per = '0;
    logic [PW-1:0] cfg_high = '0;
    logic [N_CH-1:0] led, busy;
    logic          tick;
`ifdef LED_SYNC_EN
    logic          sync = 1'b0;
`endif
    int checks = 0;
    int errors = 0;

    led_blink_bank #(.N_CH(N_CH), .TICK_DIV(TD), .PER_W(PW)) dut (
        .clk(clk),
        .aclr(aclr),
`ifdef LED_SYNC_EN
        .sync(sync),
`endif
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode),
        .cfg_per(cfg_per),
        .cfg_high(cfg_high),
        .led(led),
        .busy(busy),
        .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // waits for a tick cycle and issues a write that lands on the tick edge
    task automatic write_on_tick(input logic [2:0] ch, input logic [1:0] m, input logic [PW-1:0] p, input logic [PW-1:0] h);
        int n = 0;
        @(negedge clk);
        while (!tick && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tick_wait", {31'd0, tick}, 32'd1);
        cfg_we = 1'b1; cfg_ch = ch; cfg_mode = m; cfg_per = p; cfg_high = h;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic check_tick_after_release(input string tag);
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            @(negedge clk);
            check(tag, {31'd0, tick}, {31'd0, (n % TD) == TD - 1});
        end
    endtask

    initial begin
        #2;
        check("rst_led", {26'd0, led}, 32'd0);
        check("rst_busy", {26'd0, busy}, 32'd0);
        check("rst_tick", {31'd0, tick}, 32'd0);
        #10 aclr = 1'b0;
        check_tick_after_release("tick_first");

        // write to a channel index that does not exist
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 3'd6; cfg_mode = 2'd1; cfg_per = 4'd4; cfg_high = 4'd4;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            check("bad_ch_led", {26'd0, led}, 32'd0);
            check("bad_ch_busy", {26'd0, busy}, 32'd0);
        end

        // BLINK P=4 H=1: high 4, low 12
        write_on_tick(3'd0, 2'd2, 4'd4, 4'd1);
        for (int n = 1; n <= 32; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("blink_ch0", {31'd0, led[0]}, {31'd0, ((n - 1) % 16) < 4});
        end

        // ONESHOT P=5 H=3: busy 20 cycles, led first 12
        write_on_tick(3'd3, 2'd3, 4'd5, 4'd3);
        for (int n = 1; n <= 28; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("oneshot_busy3", {31'd0, busy[3]}, {31'd0, n <= 20});
            check("oneshot_led3", {31'd0, led[3]}, {31'd0, n <= 12});
        end

        // ON, then BLINK with H=0 forces off
        write_on_tick(3'd1, 2'd1, 4'd4, 4'd0);
        @(posedge clk);
        @(negedge clk);
        check("on_ch1", {31'd0, led[1]}, 32'd1);
        write_on_tick(3'd1, 2'd2, 4'd4, 4'd0);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("h0_ch1", {31'd0, led[1]}, 32'd0);
        end

        write_on_tick(3'd2, 2'd2, 4'd4, 4'd7);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("h_ge_p_ch2", {31'd0, led[2]}, 32'd1);
        end

        write_on_tick(3'd4, 2'd2, 4'd0, 4'd1);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("p0_ch4", {31'd0, led[4]}, 32'd1);
        end

        // long ONESHOT aborted by asynchronous reset
        write_on_tick(3'd5, 2'd3, 4'd15, 4'd15);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy5", {31'd0, busy[5]}, 32'd1);
        check("pre_rst_led5", {31'd0, led[5]}, 32'd1);
        #2 aclr = 1'b1;
        #1;
        check("async_rst_led", {26'd0, led}, 32'd0);
        check("async_rst_busy", {26'd0, busy}, 32'd0);
        check("async_rst_tick", {31'd0, tick}, 32'd0);
        @(negedge clk);
        #2 aclr = 1'b0;
        check_tick_after_release("tick_after_rst");
        check("post_rst_led", {26'd0, led}, 32'd0);
        check("post_rst_busy", {26'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
